uart_cmd_rx: RTL and testbench

//  UART receive front end of the register-access link, opposite end of the cmd-response transmitter.

---
 rtl/uart_cmd_rx_if.sv | 16 +
 rtl/uart_cmd_rx.sv | 187 ++++++++++++++++++
 tb/tb_uart_cmd_rx.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_rx_if.sv
// Packet handshake between the UART command receiver and the command decoder/FIFO.
// cmd_pkt is {cmd_type, addr, data}; master drives valid/packet, slave drives ready.
interface uart_cmd_rx_if;
  typedef struct packed {
    logic [7:0] cmd_type;
    logic [7:0] addr;
    logic [7:0] data;
  } cmd_packet_t;

  cmd_packet_t cmd_pkt;
  logic        pkt_valid;
  logic        pkt_ready;

  modport master (output cmd_pkt, output pkt_valid, input pkt_ready);
  modport slave  (input cmd_pkt, input pkt_valid, output pkt_ready);
endinterface

// File: rtl/uart_cmd_rx.sv
// Oversampling 8N1 UART receiver that assembles {cmd_type, addr, data} packets.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.
module uart_cmd_rx #(
  parameter int OVERSAMPLE   = 16,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          os_tick,
  input  logic          rx,
  uart_cmd_rx_if.master pkt,
  output logic          frame_err,
  output logic          overrun_err,
  output logic          busy
);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int TOW = $clog2(TIMEOUT_BITS * OVERSAMPLE + 1);
  localparam logic [TW-1:0]  BIT_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TOW-1:0] TO_LIMIT = TOW'(TIMEOUT_BITS * OVERSAMPLE);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [TW-1:0]  START_TICK = TW'(OVERSAMPLE / 2);
`else
  localparam logic [TW-1:0]  START_TICK = TW'(OVERSAMPLE / 2 - 1);
`endif

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  rx_state_t      state;
  logic           rx_meta;
  logic           rx_sync;
  logic           rx_prev;
  logic [TW-1:0]  tick_cnt;
  logic [2:0]     bit_cnt;
  logic [7:0]     shift;
  logic [1:0]     byte_idx;
  logic [7:0]     cmd_type;
  logic [7:0]     addr;
  logic [TOW-1:0] to_cnt;
  logic           start_edge;
  logic           sample_bit;
`ifdef UART_RX_MAJORITY_EN
  logic [1:0]     hist;
`endif

  // Two-flop synchronizer plus edge/history tracking of the synced line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
      hist    <= 2'b11;
`endif
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
`ifdef UART_RX_MAJORITY_EN
      if (os_tick) begin
        hist <= {hist[0], rx_sync};
      end
`endif
    end
  end

  // Bit decision: at the decision tick, hist holds the two preceding tick samples
  always_comb begin
    start_edge = rx_prev & ~rx_sync;
`ifdef UART_RX_MAJORITY_EN
    sample_bit = maj3(hist[1], hist[0], rx_sync);
`else
    sample_bit = rx_sync;
`endif
  end

  assign busy = (state != RX_IDLE) || (byte_idx != 2'd0);

  // Receive FSM, packet assembly, timeout and output handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RX_IDLE;
      tick_cnt      <= '0;
      bit_cnt       <= 3'd0;
      shift         <= 8'h00;
      byte_idx      <= 2'd0;
      cmd_type      <= 8'h00;
      addr          <= 8'h00;
      to_cnt        <= '0;
      frame_err     <= 1'b0;
      overrun_err   <= 1'b0;
      pkt.cmd_pkt   <= '0;
      pkt.pkt_valid <= 1'b0;
    end else begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      if (pkt.pkt_valid && pkt.pkt_ready) begin
        pkt.pkt_valid <= 1'b0;
      end

      // A partial packet with no new start edge for too long is silently dropped
      if ((byte_idx == 2'd0) || ((state == RX_IDLE) && start_edge)) begin
        to_cnt <= '0;
      end else if (os_tick && (to_cnt != TO_LIMIT)) begin
        to_cnt <= to_cnt + TOW'(1);
      end
      if (to_cnt == TO_LIMIT) begin
        byte_idx <= 2'd0;
      end

      case (state)
        RX_IDLE: begin
          if (start_edge) begin
            state    <= RX_START;
            tick_cnt <= '0;
          end
        end
        RX_START: begin
          if (os_tick) begin
            if (tick_cnt == START_TICK) begin
              tick_cnt <= '0;
              bit_cnt  <= 3'd0;
              state    <= sample_bit ? RX_IDLE : RX_DATA;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        RX_DATA: begin
          if (os_tick) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              shift    <= {sample_bit, shift[7:1]};
              if (bit_cnt == 3'd7) begin
                state <= RX_STOP;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        RX_STOP: begin
          if (os_tick) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              state    <= RX_IDLE;
              if (!sample_bit) begin
                frame_err <= 1'b1;
                byte_idx  <= 2'd0;
              end else begin
                case (byte_idx)
                  2'd0: begin
                    cmd_type <= shift;
                    byte_idx <= 2'd1;
                  end
                  2'd1: begin
                    addr     <= shift;
                    byte_idx <= 2'd2;
                  end
                  default: begin
                    byte_idx <= 2'd0;
                    if (!pkt.pkt_valid || pkt.pkt_ready) begin
                      pkt.cmd_pkt   <= {cmd_type, addr, shift};
                      pkt.pkt_valid <= 1'b1;
                    end else begin
                      overrun_err <= 1'b1;
                    end
                  end
                endcase
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        default: begin
          state <= RX_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: serial stimulus, scoreboard queue popped on each accepted packet.
module tb_uart_cmd_rx;
  localparam int OS     = 16;
  localparam int DIV    = 2;
  localparam int BITCLK = OS * DIV;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic os_tick = 1'b0;
  logic rx      = 1'b1;
  logic frame_err;
  logic overrun_err;
  logic busy;

  int checks  = 0;
  int errors  = 0;
  int fe_cnt  = 0;
  int ov_cnt  = 0;
  int pkt_cnt = 0;
  logic [23:0] exp_q[$];
  logic [23:0] last_pkt  = 24'h0;
  logic        hold_prev = 1'b0;

  uart_cmd_rx_if pkt ();

  uart_cmd_rx #(.OVERSAMPLE(OS), .TIMEOUT_BITS(20)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .os_tick     (os_tick),
    .rx          (rx),
    .pkt         (pkt),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // os_tick: one-clock strobe every DIV clocks
  initial begin
    forever begin
      @(posedge clk);
      #1 os_tick = ~os_tick;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitor: error pulse counting, held-packet stability and scoreboard pops
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (frame_err) fe_cnt++;
      if (overrun_err) ov_cnt++;
      if (hold_prev) check("hold_stable", pkt.cmd_pkt, last_pkt);
      if (pkt.pkt_valid && pkt.pkt_ready) begin
        pkt_cnt++;
        if (exp_q.size() == 0) check("pkt_unexpected", pkt.cmd_pkt, 32'hFFFF_FFFF);
        else check("pkt_data", pkt.cmd_pkt, exp_q.pop_front());
      end
      hold_prev = pkt.pkt_valid && !pkt.pkt_ready;
      last_pkt  = pkt.cmd_pkt;
    end
  end

  task automatic hold(input logic v, input int clks);
    rx = v;
    repeat (clks) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    hold(1'b0, BITCLK);
    for (int i = 0; i < 8; i++) hold(b[i], BITCLK);
    hold(stop, BITCLK);
    hold(1'b1, BITCLK);
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a, 1'b1);
    send_byte(b, 1'b1);
    send_byte(c, 1'b1);
  endtask

  task automatic send_byte_spiky(input logic [7:0] b);
    hold(1'b0, BITCLK);
    for (int i = 0; i < 8; i++) begin
      hold(b[i], BITCLK / 2 - 1);
      hold(~b[i], 2);
      hold(b[i], BITCLK / 2 - 1);
    end
    hold(1'b1, 2 * BITCLK);
  endtask

  initial begin
    pkt.pkt_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_valid", pkt.pkt_valid, 0);
    check("rst_cmd", pkt.cmd_pkt, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun_err, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    hold(1'b1, BITCLK);

    // 1: basic packet with consumer ready
    pkt.pkt_ready = 1'b1;
    exp_q.push_back(24'h012AC3);
    send_pkt(8'h01, 8'h2A, 8'hC3);
    check("t1_sb_empty", exp_q.size(), 0);
    check("t1_pkt_cnt", pkt_cnt, 1);
    check("t1_busy", busy, 0);

    // 2: overrun while a packet is held
    pkt.pkt_ready = 1'b0;
    send_pkt(8'h01, 8'h2A, 8'hC3);
    check("t2_valid_held", pkt.pkt_valid, 1);
    check("t2_cmd_held", pkt.cmd_pkt, 32'h012AC3);
    send_pkt(8'h02, 8'h10, 8'hFF);
    check("t2_overrun_cnt", ov_cnt, 1);
    check("t2_cmd_kept", pkt.cmd_pkt, 32'h012AC3);
    exp_q.push_back(24'h012AC3);
    pkt.pkt_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t2_valid_drop", pkt.pkt_valid, 0);
    check("t2_sb_empty", exp_q.size(), 0);
    check("t2_pkt_cnt", pkt_cnt, 2);

    // 3: framing error, then realigned packet
    send_byte(8'h55, 1'b0);
    check("t3_frame_cnt", fe_cnt, 1);
    check("t3_busy", busy, 0);
    exp_q.push_back(24'h012AC3);
    send_pkt(8'h01, 8'h2A, 8'hC3);
    check("t3_sb_empty", exp_q.size(), 0);
    check("t3_pkt_cnt", pkt_cnt, 3);

    // 4: partial packet timeout
    send_byte(8'h01, 1'b1);
    send_byte(8'h2A, 1'b1);
    check("t4_busy_partial", busy, 1);
    hold(1'b1, 25 * BITCLK);
    check("t4_busy_timeout", busy, 0);
    exp_q.push_back(24'h030405);
    send_pkt(8'h03, 8'h04, 8'h05);
    check("t4_sb_empty", exp_q.size(), 0);
    check("t4_pkt_cnt", pkt_cnt, 4);
    check("t4_frame_cnt", fe_cnt, 1);

    // 5: short low glitch on idle line
    hold(1'b0, (OS / 4) * DIV);
    check("t5_busy_start", busy, 1);
    hold(1'b1, 2 * BITCLK);
    check("t5_busy_after", busy, 0);
    check("t5_pkt_cnt", pkt_cnt, 4);
    check("t5_frame_cnt", fe_cnt, 1);

    // 6: reset in the middle of a byte
    pkt.pkt_ready = 1'b0;
    send_pkt(8'h11, 8'h22, 8'h33);
    check("t6_cmd_held", pkt.cmd_pkt, 32'h112233);
    send_byte(8'hA5, 1'b1);
    hold(1'b0, BITCLK);
    hold(1'b1, BITCLK);
    hold(1'b0, BITCLK / 2);
    check("t6_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", pkt.pkt_valid, 0);
    check("t6_rst_cmd", pkt.cmd_pkt, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_frame_err", frame_err, 0);
    check("t6_rst_overrun", overrun_err, 0);
    hold(1'b1, 4);
    rst_n = 1'b1;
    pkt.pkt_ready = 1'b1;
    hold(1'b1, BITCLK);
    exp_q.push_back(24'hA0B1C2);
    send_pkt(8'hA0, 8'hB1, 8'hC2);
    check("t6_sb_empty", exp_q.size(), 0);
    check("t6_pkt_cnt", pkt_cnt, 5);
    check("t6_overrun_cnt", ov_cnt, 1);

`ifdef UART_RX_MAJORITY_EN
    // Spikes at each data-bit centre are outvoted
    exp_q.push_back(24'h5A3CF0);
    send_byte_spiky(8'h5A);
    send_byte_spiky(8'h3C);
    send_byte_spiky(8'hF0);
    check("maj_sb_empty", exp_q.size(), 0);
    check("maj_frame_cnt", fe_cnt, 1);
`endif

    // 7: break produces a single framing error and no restart
    hold(1'b0, 30 * BITCLK);
    check("t7_frame_cnt", fe_cnt, 2);
    check("t7_busy_break", busy, 0);
    hold(1'b1, 2 * BITCLK);
    check("t7_busy_idle", busy, 0);
    check("t7_frame_cnt_end", fe_cnt, 2);
    check("end_overrun_cnt", ov_cnt, 1);
    check("end_sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
